inv_sub_bytes_seq: RTL
======================

# inv_sub_bytes_seq

Sequential, parametrised AES SubBytes/InvSubBytes engine for the decryption datapath. It accepts a word of NUM_BYTES bytes over a valid/ready handshake and substitutes LANES bytes per cycle through LANES S-box instances, time-multiplexed over NUM_BYTES/LANES beats. It passes a 4-bit round tag through alongside the data and sits between the AddRoundKey and InvShiftRows stages. Sized from a single 32-bit word up to the full 128-bit state.

## Interface
- NUM_BYTES, 16, bytes per word; must be a multiple of LANES.
- LANES, 4, number of S-box instances, which is the bytes substituted per cycle; BEATS = NUM_BYTES/LANES.
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  input word present.
- in_ready  output  1  block can accept a word this cycle.
- in_data  input  8*NUM_BYTES  byte i at bits [8i+7:8i].
- in_round  input  4  round tag, carried through unchanged.
- in_mode  input  1  1 = inverse S-box, 0 = forward S-box (see Configuration).
- out_valid  output  1  result word present.
- out_ready  input  1  consumer accepts the result.
- out_data  output  8*NUM_BYTES  substituted word, registered.
- out_round  output  4  tag captured with the word.
- busy  output  1  high in SUB or DONE.

## Operation
- States:
  - IDLE: in_ready=1.
  - SUB: processes beats.
  - DONE: holds the result.
- IDLE -> SUB on in_valid&&in_ready.
  - Captures in_data into the work register, plus in_round and in_mode.
  - Clears the beat counter.
- SUB, each cycle, for beat k:
  - Bytes k*LANES .. k*LANES+LANES-1 pass through the selected S-box.
  - Results are written into the same byte positions of the work register.
  - k increments.
  - After beat BEATS-1: -> DONE.
- The beat counter is ceil(log2(BEATS+1)) bits wide and never wraps within a word; it is cleared on every accept.
- DONE:
  - out_valid=1; out_data equals the work register and out_round equals the captured tag.
  - Both are stable until out_valid&&out_ready.
- DONE with out_ready=1:
  - in_ready=1 in the same cycle.
  - If in_valid is also high, a new word is accepted -> SUB (back-to-back).
  - Otherwise -> IDLE.
- DONE with out_ready=0: hold. in_ready=0.
- in_ready = (state==IDLE) || (state==DONE && out_ready). It is forced 0 while rst is high.
- in_valid is ignored in SUB. Input changes after accept do not affect the in-flight word.
- Reset mid-operation: the in-flight word is discarded. No out_valid is produced for it.
- Reset values: state=IDLE, out_valid=0, out_data=0, out_round=0, busy=0, beat counter=0.

## Timing
- Accept edge E0 -> out_valid rises at edge E_BEATS. Latency is BEATS cycles (4 at defaults).
- With out_ready held high, sustained throughput is one word per BEATS+1 cycles.
- LANES=NUM_BYTES (BEATS=1): result at the first edge after accept; period 2 cycles.
- S-box lookups are combinational from the work register. Only one register stage exists per beat.

## Configuration
- Macro: SUB_BYTES_FWD_EN.
- Defined:
  - Forward S-box tables are compiled in alongside the inverse ones.
  - in_mode (captured at accept) selects the table for the whole word.
- Undefined:
  - Forward tables are omitted.
  - in_mode is ignored and all words use the inverse S-box.
  - The port remains present.

## Test plan
- Defaults, single word:
  - Stimulus: in_data all bytes 0x63, in_round=4'hA, in_mode=1.
  - Response: out_data all 0x00 and out_round=4'hA; out_valid exactly 4 cycles after accept.
- Mixed bytes, LANES=4, NUM_BYTES=4:
  - Stimulus: in_data=32'h00_01_7C_FF (byte3..byte0).
  - Response: out_data=32'h52_09_01_7D at the first edge after accept.
- Backpressure:
  - Stimulus: out_ready=0 for 10 cycles after out_valid.
  - Response: out_data, out_round and out_valid remain stable; in_ready=0. On release, back-to-back accept in the same cycle; next out_valid 5 cycles later.
- Reset mid-operation:
  - Stimulus: assert rst during beat 2.
  - Response: out_valid=0, out_data=0, in_ready=0 during reset; in_ready=1 the cycle after release; no stale result emitted.
- SUB_BYTES_FWD_EN defined:
  - Stimulus: in_mode=0, bytes 0x00/0x01/0x53/0xFF.
  - Response: 0x63/0x7C/0xED/0x16.
  - Stimulus: the same word with in_mode=1.
  - Response: 0x52/0x09/0x50/0x7D.
- SUB_BYTES_FWD_EN undefined:
  - Stimulus: in_mode=0, byte 0x63.
  - Response: output 0x00 (inverse used).

Source files
------------

// File: rtl/inv_sub_bytes_seq.sv
// Sequential AES (Inv)SubBytes engine: LANES S-boxes, NUM_BYTES/LANES beats per word.
// Optional macro SUB_BYTES_FWD_EN compiles in the forward S-box, selected per word by in_mode.
module inv_sub_bytes_seq #(
    parameter int NUM_BYTES = 16,
    parameter int LANES     = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [8*NUM_BYTES-1:0]   in_data,
    input  logic [3:0]               in_round,
    input  logic                     in_mode,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [8*NUM_BYTES-1:0]   out_data,
    output logic [3:0]               out_round,
    output logic                     busy
);

    localparam int BEATS = NUM_BYTES / LANES;
    localparam int CW    = $clog2(BEATS + 1);
    localparam logic [CW-1:0] LAST_BEAT = CW'(BEATS - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SUB  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // GF(2^8) multiply modulo x^8+x^4+x^3+x+1
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] t;
        p = 8'h00;
        t = a;
        for (int i = 0; i < 8; i++) begin
            p = p ^ (b[i] ? t : 8'h00);
            t = {t[6:0], 1'b0} ^ (t[7] ? 8'h1B : 8'h00);
        end
        return p;
    endfunction

    // Multiplicative inverse as x^254 (maps 0 to 0)
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] r;
        logic [7:0] t;
        t = gf_mul(x, x);
        r = t;
        for (int i = 0; i < 6; i++) begin
            t = gf_mul(t, t);
            r = gf_mul(r, t);
        end
        return r;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
        return (x << n) | (x >> (8 - n));
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] x);
        return gf_inv(rotl8(x, 1) ^ rotl8(x, 3) ^ rotl8(x, 6) ^ 8'h05);
    endfunction

`ifdef SUB_BYTES_FWD_EN
    function automatic logic [7:0] fwd_sbox(input logic [7:0] x);
        logic [7:0] b;
        b = gf_inv(x);
        return b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
    endfunction
`endif

    state_t                   r_state;
    state_t                   w_next_state;
    logic                     w_in_ready;
    logic                     w_accept;
    logic [8*NUM_BYTES-1:0]   r_work;
    logic [3:0]               r_round;
    logic [CW-1:0]            r_beat;
    logic                     r_out_valid;
    logic                     r_busy;
    logic [7:0]               w_lane_in  [LANES];
    logic [7:0]               w_lane_out [LANES];

`ifdef SUB_BYTES_FWD_EN
    logic                     r_mode;
`else
    logic                     w_unused_mode;
    assign w_unused_mode = in_mode;
`endif

    // Next-state and handshake decode
    always_comb begin
        w_next_state = r_state;
        w_in_ready   = 1'b0;
        w_accept     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_in_ready = 1'b1;
                if (in_valid) begin
                    w_accept     = 1'b1;
                    w_next_state = ST_SUB;
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_SUB: begin
                if (r_beat == LAST_BEAT) begin
                    w_next_state = ST_DONE;
                end else begin
                    w_next_state = ST_SUB;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    w_in_ready = 1'b1;
                    if (in_valid) begin
                        w_accept     = 1'b1;
                        w_next_state = ST_SUB;
                    end else begin
                        w_next_state = ST_IDLE;
                    end
                end else begin
                    w_next_state = ST_DONE;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // State register plus registered status outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_next_state;
            r_out_valid <= (w_next_state == ST_DONE);
            r_busy      <= (w_next_state == ST_SUB) || (w_next_state == ST_DONE);
        end
    end

    // One-hot AND-OR select of the current beat's bytes
    always_comb begin
        for (int j = 0; j < LANES; j++) begin
            w_lane_in[j] = 8'h00;
        end
        for (int b = 0; b < BEATS; b++) begin
            for (int j = 0; j < LANES; j++) begin
                w_lane_in[j] = w_lane_in[j] |
                    ((r_beat == CW'(b)) ? r_work[(b*LANES+j)*8 +: 8] : 8'h00);
            end
        end
    end

    // S-box lanes
    always_comb begin
        for (int j = 0; j < LANES; j++) begin
`ifdef SUB_BYTES_FWD_EN
            w_lane_out[j] = r_mode ? inv_sbox(w_lane_in[j]) : fwd_sbox(w_lane_in[j]);
`else
            w_lane_out[j] = inv_sbox(w_lane_in[j]);
`endif
        end
    end

    // Work register: load on accept, write back one beat per SUB cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_work  <= '0;
            r_round <= 4'h0;
            r_beat  <= '0;
`ifdef SUB_BYTES_FWD_EN
            r_mode  <= 1'b1;
`endif
        end else if (w_accept) begin
            r_work  <= in_data;
            r_round <= in_round;
            r_beat  <= '0;
`ifdef SUB_BYTES_FWD_EN
            r_mode  <= in_mode;
`endif
        end else if (r_state == ST_SUB) begin
            for (int b = 0; b < BEATS; b++) begin
                for (int j = 0; j < LANES; j++) begin
                    if (r_beat == CW'(b)) begin
                        r_work[(b*LANES+j)*8 +: 8] <= w_lane_out[j];
                    end
                end
            end
            r_beat <= r_beat + CW'(1);
        end
    end

    assign in_ready  = w_in_ready & ~rst;
    assign out_valid = r_out_valid;
    assign out_data  = r_work;
    assign out_round = r_round;
    assign busy      = r_busy;

endmodule
